// File: rtl/mem_pkg.sv
// Shared widths and word/address types for the sram_mem storage block.
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 8;

    typedef logic [MEM_DATA_W-1:0] word_t;
    typedef logic [MEM_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/sram_mem_array.sv
// Plain 2**ADDR_W x DATA_W storage with a synchronous write port and a
// registered read port; a read and write to the same word return the old data.
module sram_mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    // The read samples mem_q before this edge's write lands: read-before-write.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr_i) begin
            rd_data_d = '0;
        end else if (rd_en_i) begin
            rd_data_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sram_mem.sv
// Single-port synchronous RAM: chip-select qualification and synchronous
// reset of the read register; stored contents are never touched by reset.
module sram_mem
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic wr_en;
    logic rd_en;

    // Reset drops any access requested in the same cycle.
    assign wr_en = cs & we & ~rst;
    assign rd_en = cs & re & ~rst;

    sram_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .rd_en_i   (rd_en),
        .rd_clr_i  (rst),
        .addr_i    (addr),
        .wr_data_i (data_in),
        .rd_data_o (data_out)
    );

endmodule

// File: tb/tb_sram_mem.sv
// Self-checking bench for sram_mem: directed vectors, a word-array model
// checked every cycle, and literal expectations at the key points.
module tb_sram_mem;
    import mem_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  cs = 1'b0;
    logic  we = 1'b0;
    logic  re = 1'b0;
    addr_t addr = '0;
    word_t data_in = '0;
    word_t data_out;

    int checks = 0;
    int failures = 0;

    word_t mdl_mem [256];
    bit    mdl_written [256];
    word_t mdl_out = '0;
    bit    mdl_valid = 1'b0;

    sram_mem dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: data_out=%02h expected=%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: reset clears output; otherwise a read takes the old word, then the write lands.
    always @(posedge clk) begin
        if (rst) begin
            mdl_out   = '0;
            mdl_valid = 1'b1;
        end else if (cs) begin
            if (re) begin
                mdl_out   = mdl_mem[addr];
                mdl_valid = mdl_valid && mdl_written[addr];
            end
            if (we) begin
                mdl_mem[addr]     = data_in;
                mdl_written[addr] = 1'b1;
            end
        end
        #1;
        if (mdl_valid) check("model", data_out, mdl_out);
    end

    task automatic cyc(input bit r, input bit c, input bit w, input bit rd,
                       input addr_t a, input word_t d);
        @(negedge clk);
        rst = r; cs = c; we = w; re = rd; addr = a; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mdl_mem[i]     = '0;
            mdl_written[i] = 1'b0;
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("reset_value", data_out, 8'h00);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF); idle();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'hAA); idle();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'hBB); idle();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 8'h33); idle();
        check("write_no_read_hold", data_out, 8'h00);

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00); check("read_a0", data_out, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00); check("read_a1", data_out, 8'hAA);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00); check("read_a2", data_out, 8'hBB);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h55);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00); check("cs_low_read_hold", data_out, 8'hBB);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00); check("cs_low_write_blocked", data_out, 8'h33);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h11); check("rbw_old_data", data_out, 8'hAA);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00); check("rbw_new_data", data_out, 8'h11);

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00); check("pre_reset_read", data_out, 8'hBB);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h77); check("reset_clears_out", data_out, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00); check("reset_write_dropped", data_out, 8'hFF);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h5A); idle();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00); check("top_addr_read", data_out, 8'h5A);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00); check("addr0_unaffected", data_out, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("idle_hold", data_out, 8'h5A);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
